spi_byte_frontend: RTL and testbench

//  Clock-domain front end for the SPI link into the Ascon accelerator.
//  - Oversamples the pad-level SPI pins (SCK, CSB, MOSI) on the system clock.
//  - Assembles received bits into bytes, MSB first, SPI mode 0.
//  - Serialises the readout bytes onto MISO.
//  - Sits between the uio pads and the register/command decoder that loads the 128-bit

---
 rtl/spi_byte_frontend.sv | 157 +++++++++++++++
 tb/tb_spi_byte_frontend.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_frontend.sv
// SPI mode-0 byte front end: synchronises the SPI pins onto clk, assembles
// MOSI bytes MSB first and serialises readout bytes onto MISO.
module spi_byte_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       csb_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       rx_abort,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_e;

  // Flush window after reset: the synchronizers hold their reset values for
  // SYNC_STAGES cycles, so WAIT_IDLE must not trust csb_s until real pin
  // values have propagated through.
  localparam int FW = $clog2(SYNC_STAGES + 2) + 1;

  logic [SYNC_STAGES-1:0] sck_sync_q, csb_sync_q, mosi_sync_q;
  logic                   sck_d_q, csb_d_q;
  logic                   sck_s, csb_s, mosi_s;
  logic                   sck_rise, sck_fall, csb_rise, csb_fall;

  state_e      state_q;
  logic [FW-1:0] flush_q;
  logic        flush_done;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_shift_q, tx_shift_q, tx_next_q, rx_byte_q;
  logic        rx_valid_q, rx_first_q, rx_abort_q, tx_req_q;
  logic        first_flag_q, load_first_q, load_next_q, done_q;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign csb_s  = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d_q;
  assign sck_fall = ~sck_s & sck_d_q;
  assign csb_rise = csb_s & ~csb_d_q;
  assign csb_fall = ~csb_s & csb_d_q;

  assign flush_done = (flush_q == FW'(SYNC_STAGES + 1));

  // Pin synchronizers plus one history flop for edge detection on SCK/CSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      csb_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      csb_d_q     <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], csb_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_d_q     <= sck_s;
      csb_d_q     <= csb_s;
    end
  end

  // Frame FSM with the rx/tx shift datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_IDLE;
      flush_q      <= '0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_next_q    <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      rx_abort_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      first_flag_q <= 1'b0;
      load_first_q <= 1'b0;
      load_next_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      tx_req_q   <= 1'b0;
      done_q     <= 1'b0;
      // Readout byte is always presented one clk after the request.
      if (tx_req_q) tx_next_q <= tx_data;
      unique case (state_q)
        WAIT_IDLE: begin
          if (!flush_done) flush_q <= flush_q + FW'(1);
          else if (csb_s)  state_q <= IDLE;
        end
        IDLE: begin
          if (csb_fall) begin
            state_q      <= ACTIVE;
            bit_cnt_q    <= '0;
            first_flag_q <= 1'b1;
            tx_req_q     <= 1'b1;
            load_first_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (csb_rise) begin
            // End of frame beats any same-cycle SCK edge; partial byte dropped.
            state_q      <= IDLE;
            rx_abort_q   <= (bit_cnt_q != 3'd0);
            load_first_q <= 1'b0;
            load_next_q  <= 1'b0;
          end else begin
            if (load_first_q) begin
              tx_shift_q   <= tx_data;
              load_first_q <= 1'b0;
            end
            if (done_q) begin
              rx_valid_q   <= 1'b1;
              rx_byte_q    <= rx_shift_q;
              rx_first_q   <= first_flag_q;
              first_flag_q <= 1'b0;
              tx_req_q     <= 1'b1;
              load_next_q  <= 1'b1;
            end
            if (sck_rise) begin
              rx_shift_q <= {rx_shift_q[6:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) done_q <= 1'b1;
            end
            if (sck_fall) begin
              if (load_next_q) begin
                tx_shift_q  <= tx_next_q;
                load_next_q <= 1'b0;
              end else begin
                tx_shift_q  <= {tx_shift_q[6:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  // MISO idles high, including the single cycle before the first byte loads.
  assign miso_o   = (state_q == ACTIVE && !load_first_q) ? tx_shift_q[7] : 1'b1;
  assign busy     = (state_q == ACTIVE);
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign rx_abort = rx_abort_q;
  assign tx_req   = tx_req_q;

endmodule

// File: tb/tb_spi_byte_frontend.sv
// Bench for spi_byte_frontend: randomized SPI frames, scoreboard of expected
// received bytes / aborts, MISO bits checked against the readout byte stream.
module tb_spi_byte_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck_i = 1'b0, csb_i = 1'b1, mosi_i = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso_o, rx_valid, rx_first, rx_abort, tx_req, busy;
  logic [7:0] rx_byte;

  spi_byte_frontend #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck_i(sck_i), .csb_i(csb_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_first(rx_first),
    .rx_abort(rx_abort), .tx_req(tx_req), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic first; } rx_t;

  int         checks = 0, errors = 0;
  rx_t        expq[$];
  logic [7:0] txq[$];
  logic [7:0] txforce[$];
  int         exp_abort = 0;
  logic [7:0] mb [0:7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Readout responder: answers each tx_req with a byte one clk later.
  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        if (txforce.size() > 0) v = txforce.pop_front();
        else v = 8'($urandom);
        tx_data = v;
        txq.push_back(v);
      end
    end
  end

  // Monitor: pops the scoreboard on each strobe and checks pulse rules.
  initial begin
    rx_t  e;
    logic pv = 1'b0, pa = 1'b0, pt = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        chk("valid_not_with_abort", rx_abort, 1'b0);
        chk("valid_not_back2back", pv, 1'b0);
        chk("rx_valid_expected", expq.size() > 0, 1'b1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("rx_byte", rx_byte, e.b);
          chk("rx_first", rx_first, e.first);
        end
      end
      if (rx_abort) begin
        chk("abort_not_back2back", pa, 1'b0);
        chk("rx_abort_expected", exp_abort > 0, 1'b1);
        if (exp_abort > 0) exp_abort--;
      end
      if (tx_req) chk("tx_req_not_back2back", pt, 1'b0);
      pv = rx_valid; pa = rx_abort; pt = tx_req;
    end
  end

  // One CSB-framed transfer of nbits MOSI bits from mb[]; collide raises CSB
  // together with the last SCK rise.
  task automatic frame(input int nbits, input int half, input bit collide);
    logic [7:0] tb;
    txq.delete();
    csb_i = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      tb = mb[i/8];
      mosi_i = tb[7 - (i % 8)];
      tick(half);
      if (txq.size() > i / 8) begin
        tb = txq[i/8];
        chk("miso_bit", miso_o, tb[7 - (i % 8)]);
      end else begin
        chk("tx_req_before_byte", txq.size(), i / 8 + 1);
      end
      if (collide && i == nbits - 1) begin
        exp_abort++;
        sck_i = 1'b1;
        csb_i = 1'b1;
        tick(half);
        sck_i = 1'b0;
      end else begin
        if (i % 8 == 7) expq.push_back('{mb[i/8], (i < 8)});
        sck_i = 1'b1;
        tick(half);
        sck_i = 1'b0;
      end
    end
    if (!collide) begin
      tick(half);
      if (nbits % 8 != 0) exp_abort++;
      csb_i = 1'b1;
    end
    tick(10);
    chk("busy_after_frame", busy, 1'b0);
    chk("miso_after_frame", miso_o, 1'b1);
    chk("tx_req_count", txq.size(), 1 + (collide ? (nbits - 1) / 8 : nbits / 8));
    chk("rx_scoreboard_drained", expq.size(), 0);
    chk("abort_drained", exp_abort, 0);
  endtask

  initial begin
    int nb;
    tick(3);
    chk("rst_miso", miso_o, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_strobes", {rx_valid, rx_first, rx_abort, tx_req}, 4'b0000);
    rst = 1'b0;
    tick(10);

    // Directed two-byte frame with fixed readout bytes.
    txforce.push_back(8'h81);
    txforce.push_back(8'h42);
    mb[0] = 8'hA5; mb[1] = 8'h3C;
    frame(16, 8, 1'b0);
    txforce.delete();

    // Partial frame then a clean byte.
    mb[0] = 8'h6B;
    frame(5, 6, 1'b0);
    mb[0] = 8'hFF;
    frame(8, 6, 1'b0);

    // Reset in the middle of a frame with CSB held low.
    mb[0] = 8'hC3;
    csb_i = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      mosi_i = mb[0][7-i];
      tick(6); sck_i = 1'b1; tick(6); sck_i = 1'b0;
    end
    rst = 1'b1;
    tick(2);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_miso", miso_o, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi_i = i[0];
      tick(6); sck_i = 1'b1; tick(6); sck_i = 1'b0;
    end
    tick(4);
    chk("postrst_ignored_busy", busy, 1'b0);
    csb_i = 1'b1;
    tick(8);
    mb[0] = 8'h5A;
    frame(8, 6, 1'b0);

    // Four-byte burst.
    for (int k = 0; k < 4; k++) mb[k] = 8'($urandom);
    frame(32, 5, 1'b0);

    // CSB rise collides with the 8th SCK rise.
    mb[0] = 8'h99;
    frame(8, 6, 1'b1);

    // Idle pins: SCK toggling while CSB high.
    txq.delete();
    for (int i = 0; i < 12; i++) begin
      sck_i = ~sck_i;
      tick(4);
      chk("idle_miso", miso_o, 1'b1);
    end
    sck_i = 1'b0;
    tick(4);
    chk("idle_no_tx_req", txq.size(), 0);

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) mb[k] = 8'($urandom);
      nb = int'($urandom_range(1, 40));
      frame(nb, int'($urandom_range(4, 9)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
